// File: rtl/squarer_isqrt_if.sv
// Handshake bundle for the iterative square-root block.
//   power_i / power_valid_i / power_ready_o : power sample in (valid/ready)
//   amp_o / rem_o / amp_valid_o / amp_ready_i : floor root and remainder out
// master = upstream producer / downstream consumer side, slave = the root block.
interface squarer_isqrt_if #(
    parameter int unsigned IN_WIDTH = 12
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;

    logic [IN_WIDTH-1:0]  power_i;
    logic                 power_valid_i;
    logic                 power_ready_o;
    logic [OUT_WIDTH-1:0] amp_o;
    logic [OUT_WIDTH:0]   rem_o;
    logic                 amp_valid_o;
    logic                 amp_ready_i;

    modport master (
        output power_i, power_valid_i, amp_ready_i,
        input  power_ready_o, amp_o, rem_o, amp_valid_o
    );

    modport slave (
        input  power_i, power_valid_i, amp_ready_i,
        output power_ready_o, amp_o, rem_o, amp_valid_o
    );
endinterface

// File: rtl/squarer_isqrt.sv
// Iterative restoring integer square root of an accumulated power value.
// Produces one root bit per cycle; one conversion in flight.
//   clk_i   : system clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : squarer_isqrt_if.slave (power in, amp/rem out, valid/ready both sides)
module squarer_isqrt #(
    parameter int unsigned IN_WIDTH = 12
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    squarer_isqrt_if.slave  bus
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;
    localparam int unsigned R_WIDTH   = OUT_WIDTH + 2;
    localparam int unsigned CNT_W     = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    // The digit-pair walk needs an even, non-trivial input width.
    if (((IN_WIDTH % 2) != 0) || (IN_WIDTH < 4)) begin : g_width_check
        $error("squarer_isqrt: IN_WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [IN_WIDTH-1:0]  sh;
    logic [OUT_WIDTH-1:0] q;
    logic [R_WIDTH-1:0]   r;
    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] amp;
    logic [OUT_WIDTH:0]   rem;
    logic                 amp_valid;

    logic [R_WIDTH-1:0]   r_sh;
    logic [R_WIDTH-1:0]   t_val;
    logic                 ge;
    logic [OUT_WIDTH-1:0] q_nxt;
    logic [R_WIDTH-1:0]   r_nxt;

    // One restoring step: bring down the next bit pair and trial-subtract 4q+1.
    always_comb begin
        r_sh  = R_WIDTH'({r, sh[IN_WIDTH-1 -: 2]});
        t_val = {q, 2'b01};
        ge    = (r_sh >= t_val);
        q_nxt = OUT_WIDTH'({q, ge});
        r_nxt = ge ? (r_sh - t_val) : r_sh;
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            sh        <= '0;
            q         <= '0;
            r         <= '0;
            cnt       <= '0;
            amp       <= '0;
            rem       <= '0;
            amp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.power_valid_i) begin
                        sh    <= bus.power_i;
                        q     <= '0;
                        r     <= '0;
                        cnt   <= CNT_W'(OUT_WIDTH - 1);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    sh  <= {sh[IN_WIDTH-3:0], 2'b00};
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        // Final remainder is <= 2q, so the top bit is always zero.
                        amp       <= q_nxt;
                        rem       <= r_nxt[OUT_WIDTH:0];
                        amp_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.amp_ready_i) begin
                        amp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Ready is decoded from state and masked while reset is asserted.
    assign bus.power_ready_o = (state == S_IDLE) && rst_n_i;
    assign bus.amp_o         = amp;
    assign bus.rem_o         = rem;
    assign bus.amp_valid_o   = amp_valid;
endmodule

// File: tb/tb_squarer_isqrt.sv
// Scoreboard bench for squarer_isqrt: the driver queues expected root/remainder
// on each accepted power sample, the monitor pops and compares on every
// output handshake.
module tb_squarer_isqrt;
    localparam int unsigned IN_WIDTH  = 12;
    localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int power;
        int amp;
        int rem;
    } exp_t;

    exp_t exp_q[$];

    squarer_isqrt_if #(.IN_WIDTH(IN_WIDTH)) b ();

    squarer_isqrt #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference by plain search: largest a with a*a <= p.
    function automatic int ref_amp(input int p);
        int a;
        a = 0;
        while ((a + 1) * (a + 1) <= p) a++;
        return a;
    endfunction

    // Output monitor: compare every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && b.amp_valid_o && b.amp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                int   a;
                int   r;
                e = exp_q.pop_front();
                a = int'(b.amp_o);
                r = int'(b.rem_o);
                check($sformatf("amp[p=%0d]", e.power), a, e.amp);
                check($sformatf("rem[p=%0d]", e.power), r, e.rem);
                check($sformatf("identity[p=%0d]", e.power), a * a + r, e.power);
                check($sformatf("rem_le_2amp[p=%0d]", e.power), int'(r <= 2 * a), 1);
            end
        end
    end

    // Present a sample and hold it until accepted; optionally queue expectation.
    task automatic send(input int p, input int ea, input int er, input bit expect_out,
                        output int accept_cyc);
        int n;
        n = 0;
        b.power_i       = IN_WIDTH'(p);
        b.power_valid_i = 1'b1;
        while (!b.power_ready_o && n <= 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n > 100) begin
            check("accept_timeout", 0, 1);
            b.power_valid_i = 1'b0;
            accept_cyc = cyc;
            return;
        end
        if (expect_out) exp_q.push_back('{power: p, amp: ea, rem: er});
        @(posedge clk);
        #1;
        accept_cyc      = cyc;
        b.power_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!b.amp_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Directed vectors with hand-computed roots and remainders.
    int vec_p   [10] = '{1, 2, 3, 15, 16, 99, 1000, 2025, 3000, 4094};
    int vec_amp [10] = '{1, 1, 1,  3,  4,  9,   31,   45,   54,   63};
    int vec_rem [10] = '{0, 1, 2,  6,  0, 18,   39,    0,   84,  125};

    initial begin
        int t;
        int t_prev;
        int n;
        bit seen;

        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        b.power_i       = '0;
        b.power_valid_i = 1'b0;
        b.amp_ready_i   = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_amp_valid", int'(b.amp_valid_o), 0);
        check("rst_amp", int'(b.amp_o), 0);
        check("rst_rem", int'(b.rem_o), 0);
        check("rst_ready_held_low", int'(b.power_ready_o), 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", int'(b.power_ready_o), 1);

        // Zero input plus accept-to-valid latency.
        send(0, 0, 0, 1'b1, t);
        check("ready_drops_after_accept", int'(b.power_ready_o), 0);
        wait_valid(n);
        check("latency_edges", n, OUT_WIDTH);

        // Directed corner values.
        send(144, 12, 0, 1'b1, t);
        send(110, 10, 10, 1'b1, t);
        send(4095, 63, 126, 1'b1, t);

        // Back-to-back with consumer always ready: accepts 8 cycles apart.
        send(vec_p[0], vec_amp[0], vec_rem[0], 1'b1, t_prev);
        for (int i = 1; i < 10; i++) begin
            send(vec_p[i], vec_amp[i], vec_rem[i], 1'b1, t);
            check($sformatf("accept_spacing[%0d]", i), t - t_prev, OUT_WIDTH + 2);
            t_prev = t;
        end

        // Consumer stall: outputs frozen, new inputs ignored.
        wait_valid(n);
        @(posedge clk);
        #1;
        b.amp_ready_i = 1'b0;
        send(500, 22, 16, 1'b1, t);
        wait_valid(n);
        check("stall_valid_reached", int'(b.amp_valid_o), 1);
        for (int i = 0; i < 20; i++) begin
            b.power_i       = IN_WIDTH'(100 + i);
            b.power_valid_i = i[0];
            @(posedge clk);
            #1;
            check("stall_amp_valid", int'(b.amp_valid_o), 1);
            check("stall_amp", int'(b.amp_o), 22);
            check("stall_rem", int'(b.rem_o), 16);
            check("stall_ready_low", int'(b.power_ready_o), 0);
        end
        b.power_valid_i = 1'b0;
        b.amp_ready_i   = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_stall", int'(b.power_ready_o), 1);

        // Reset on the third CALC edge aborts the conversion.
        send(2000, 0, 0, 1'b0, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_amp_valid", int'(b.amp_valid_o), 0);
        check("abort_amp", int'(b.amp_o), 0);
        check("abort_rem", int'(b.rem_o), 0);
        check("abort_ready_in_reset", int'(b.power_ready_o), 0);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after_release", int'(b.power_ready_o), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (b.amp_valid_o) seen = 1'b1;
        end
        check("abort_no_valid", int'(seen), 0);
        send(2000, 44, 64, 1'b1, t);

        // Full sweep against the search-based reference.
        for (int p = 0; p < (1 << IN_WIDTH); p++) begin
            int a;
            a = ref_amp(p);
            send(p, a, p - a * a, 1'b1, t);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
